// File: rtl/modexp_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | modexp_ctrl_if : host (GO/DONE) and Montgomery-multiplier signals          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface modexp_ctrl_if #(
    parameter int BITS = 64
);
    logic            GO;
    logic [BITS-1:0] M;
    logic [BITS-1:0] E;
    logic [BITS-1:0] N;
    logic [BITS-1:0] R2;
    logic            BUSY;
    logic            DONE;
    logic [BITS-1:0] RESULT;
    logic            MM_START;
    logic [BITS-1:0] MM_A;
    logic [BITS-1:0] MM_B;
    logic [BITS-1:0] MM_N;
    logic            MM_DONE;
    logic [BITS-1:0] MM_P;

    // master: host plus MM core side; slave: the exponentiation controller
    modport master (
        output GO, M, E, N, R2, MM_DONE, MM_P,
        input  BUSY, DONE, RESULT, MM_START, MM_A, MM_B, MM_N
    );
    modport slave (
        input  GO, M, E, N, R2, MM_DONE, MM_P,
        output BUSY, DONE, RESULT, MM_START, MM_A, MM_B, MM_N
    );
endinterface

`default_nettype wire

// File: rtl/modexp_ctrl.sv
// +----------------------------------------------------------------------------+
// | modexp_ctrl : left-to-right square-and-multiply sequencer for one MM core |
// | Optional macro LEADZERO_SKIP_EN skips leading zero exponent bits.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module modexp_ctrl #(
    parameter int BITS = 64,
    parameter int CNTW = 7
) (
    input  wire logic      CLK,
    input  wire logic      RESET_N,
    modexp_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TO_MONT   = 3'd1,
        S_INIT_X    = 3'd2,
        S_SQUARE    = 3'd3,
        S_MULT      = 3'd4,
        S_FROM_MONT = 3'd5,
        S_FIN       = 3'd6,
        S_SCAN      = 3'd7
    } state_t;

    localparam logic [CNTW-1:0] c_idx_top = CNTW'(BITS - 1);
    localparam logic [CNTW-1:0] c_idx_one = CNTW'(1);
    localparam logic [BITS-1:0] c_one     = {{(BITS-1){1'b0}}, 1'b1};

    state_t          r_state, w_state_nx;
    logic            r_issued, w_issued_nx;
    logic [BITS-1:0] r_m, w_m_nx;
    logic [BITS-1:0] r_e, w_e_nx;
    logic [BITS-1:0] r_r2, w_r2_nx;
    logic [BITS-1:0] r_n, w_n_nx;
    logic [BITS-1:0] r_x, w_x_nx;
    logic [BITS-1:0] r_mb, w_mb_nx;
    logic [BITS-1:0] r_result, w_result_nx;
    logic [CNTW-1:0] r_idx, w_idx_nx;
    logic            w_mm_start;
    logic [BITS-1:0] w_mm_a, w_mm_b;
    logic            w_ebit;
    logic            w_idx_zero;
    logic [CNTW-1:0] w_idx_dec;

    assign w_ebit     = |(r_e & (c_one << r_idx));
    assign w_idx_zero = (r_idx == '0);
    assign w_idx_dec  = r_idx - c_idx_one;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state  <= S_IDLE;
            r_issued <= 1'b0;
            r_m      <= '0;
            r_e      <= '0;
            r_r2     <= '0;
            r_n      <= '0;
            r_x      <= '0;
            r_mb     <= '0;
            r_result <= '0;
            r_idx    <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_issued <= w_issued_nx;
            r_m      <= w_m_nx;
            r_e      <= w_e_nx;
            r_r2     <= w_r2_nx;
            r_n      <= w_n_nx;
            r_x      <= w_x_nx;
            r_mb     <= w_mb_nx;
            r_result <= w_result_nx;
            r_idx    <= w_idx_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_issued_nx = r_issued;
        w_m_nx      = r_m;
        w_e_nx      = r_e;
        w_r2_nx     = r_r2;
        w_n_nx      = r_n;
        w_x_nx      = r_x;
        w_mb_nx     = r_mb;
        w_result_nx = r_result;
        w_idx_nx    = r_idx;
        w_mm_start  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.GO) begin
                    w_m_nx      = bus.M;
                    w_e_nx      = bus.E;
                    w_n_nx      = bus.N;
                    w_r2_nx     = bus.R2;
                    w_issued_nx = 1'b0;
                    w_state_nx  = S_TO_MONT;
                end
            end
            S_FIN: begin
                if (!bus.GO) w_state_nx = S_IDLE;
            end
`ifdef LEADZERO_SKIP_EN
            S_SCAN: begin
                if (!bus.GO) begin
                    w_state_nx = S_IDLE;
                end else if (w_ebit) begin
                    w_x_nx = r_mb;
                    if (w_idx_zero) begin
                        w_state_nx = S_FROM_MONT;
                    end else begin
                        w_idx_nx   = w_idx_dec;
                        w_state_nx = S_SQUARE;
                    end
                end else begin
                    w_idx_nx = w_idx_dec;
                end
            end
`endif
            S_TO_MONT, S_INIT_X, S_SQUARE, S_MULT, S_FROM_MONT: begin
                // Start is gated by GO so an abort never launches a new MM op
                if (!bus.GO) begin
                    w_issued_nx = 1'b0;
                    w_state_nx  = S_IDLE;
                end else if (!r_issued) begin
                    w_mm_start  = 1'b1;
                    w_issued_nx = 1'b1;
                end else if (bus.MM_DONE) begin
                    w_issued_nx = 1'b0;
                    case (r_state)
                        S_TO_MONT: begin
                            w_mb_nx = bus.MM_P;
`ifdef LEADZERO_SKIP_EN
                            if (r_e == '0) begin
                                w_state_nx = S_INIT_X;
                            end else begin
                                w_idx_nx   = c_idx_top;
                                w_state_nx = S_SCAN;
                            end
`else
                            w_state_nx = S_INIT_X;
`endif
                        end
                        S_INIT_X: begin
                            w_x_nx = bus.MM_P;
`ifdef LEADZERO_SKIP_EN
                            w_state_nx = S_FROM_MONT;
`else
                            w_idx_nx   = c_idx_top;
                            w_state_nx = S_SQUARE;
`endif
                        end
                        S_SQUARE: begin
                            w_x_nx = bus.MM_P;
                            if (w_ebit) begin
                                w_state_nx = S_MULT;
                            end else if (w_idx_zero) begin
                                w_state_nx = S_FROM_MONT;
                            end else begin
                                w_idx_nx   = w_idx_dec;
                                w_state_nx = S_SQUARE;
                            end
                        end
                        S_MULT: begin
                            w_x_nx = bus.MM_P;
                            if (w_idx_zero) begin
                                w_state_nx = S_FROM_MONT;
                            end else begin
                                w_idx_nx   = w_idx_dec;
                                w_state_nx = S_SQUARE;
                            end
                        end
                        default: begin
                            w_result_nx = bus.MM_P;
                            w_state_nx  = S_FIN;
                        end
                    endcase
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Operands are pure functions of state and held registers, so they stay stable through the wait
    always_comb begin
        w_mm_a = '0;
        w_mm_b = '0;
        case (r_state)
            S_TO_MONT:   begin w_mm_a = r_m;   w_mm_b = r_r2;  end
            S_INIT_X:    begin w_mm_a = c_one; w_mm_b = r_r2;  end
            S_SQUARE:    begin w_mm_a = r_x;   w_mm_b = r_x;   end
            S_MULT:      begin w_mm_a = r_x;   w_mm_b = r_mb;  end
            S_FROM_MONT: begin w_mm_a = r_x;   w_mm_b = c_one; end
            default:     begin w_mm_a = '0;    w_mm_b = '0;    end
        endcase
    end

    assign bus.BUSY     = (r_state != S_IDLE) && (r_state != S_FIN);
    assign bus.DONE     = (r_state == S_FIN);
    assign bus.RESULT   = r_result;
    assign bus.MM_START = w_mm_start;
    assign bus.MM_A     = w_mm_a;
    assign bus.MM_B     = w_mm_b;
    assign bus.MM_N     = r_n;

endmodule

`default_nettype wire

// File: tb/tb_modexp_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_modexp_ctrl : bench for modexp_ctrl with a 5-cycle Montgomery MM model  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_modexp_ctrl;
    localparam int BITS = 64;
    localparam int CNTW = 7;
    localparam int LAT  = 5;
`ifdef LEADZERO_SKIP_EN
    localparam int ABORT_AT = 2;
    localparam int RESET_AT = 3;
`else
    localparam int ABORT_AT = 10;
    localparam int RESET_AT = 66;
`endif

    typedef struct {
        logic [63:0] m;
        logic [63:0] e;
        logic [63:0] n;
        logic [63:0] res;
    } vec_t;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;

    modexp_ctrl_if #(.BITS(BITS)) bus();

    modexp_ctrl #(.BITS(BITS), .CNTW(CNTW)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus.slave)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;
    int mm_starts = 0;
    int stab_err = 0;
    logic [63:0] mm_a, mm_b;
    bit mm_pend = 1'b0;
    int mm_lat = 0;

    // A*B*2^-64 mod N by bit-serial reduction
    function automatic logic [63:0] mont(input logic [63:0] a, input logic [63:0] b, input logic [63:0] n);
        logic [129:0] t;
        t = {66'd0, a} * {66'd0, b};
        for (int i = 0; i < 64; i++) begin
            if (t[0]) t = t + {66'd0, n};
            t = t >> 1;
        end
        if (t >= {66'd0, n}) t = t - {66'd0, n};
        return t[63:0];
    endfunction

    function automatic logic [63:0] r2_of(input logic [63:0] n);
        logic [129:0] t, q;
        t = 130'd1 << 128;
        q = t % {66'd0, n};
        return q[63:0];
    endfunction

    // Plain right-to-left modular exponentiation with wide integers
    function automatic logic [63:0] ref_modexp(input logic [63:0] m, input logic [63:0] e, input logic [63:0] n);
        logic [127:0] r, b, nn;
        nn = {64'd0, n};
        r  = 128'd1 % nn;
        b  = {64'd0, m} % nn;
        for (int i = 0; i < 64; i++) begin
            if (e[i]) r = (r * b) % nn;
            b = (b * b) % nn;
        end
        return r[63:0];
    endfunction

    function automatic int exp_starts(input logic [63:0] e);
        int pop;
        int h;
        pop = $countones(e);
        h = 0;
        for (int i = 0; i < 64; i++) if (e[i]) h = i;
`ifdef LEADZERO_SKIP_EN
        if (e == 64'd0) return 3;
        return 2 + h + pop - 1;
`else
        return 3 + BITS + pop;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // MM core model: samples away from the edge, answers LAT cycles after a start
    initial begin
        bus.MM_DONE = 1'b0;
        bus.MM_P    = '0;
        forever begin
            @(posedge CLK);
            #2;
            bus.MM_DONE = 1'b0;
            if (mm_pend) begin
                if (bus.BUSY && (bus.MM_A !== mm_a || bus.MM_B !== mm_b)) stab_err++;
                mm_lat--;
                if (mm_lat == 0) begin
                    bus.MM_DONE = 1'b1;
                    bus.MM_P    = mont(mm_a, mm_b, bus.MM_N);
                    mm_pend     = 1'b0;
                end
            end
            if (bus.MM_START === 1'b1) begin
                mm_a = bus.MM_A;
                mm_b = bus.MM_B;
                mm_starts++;
                mm_pend = 1'b1;
                mm_lat  = LAT;
            end
        end
    end

    task automatic run_one(input logic [63:0] m, input logic [63:0] e, input logic [63:0] n,
                           output logic [63:0] res, output int starts);
        int cyc;
        @(posedge CLK); #1;
        bus.M  = m;
        bus.E  = e;
        bus.N  = n;
        bus.R2 = r2_of(n);
        mm_starts = 0;
        stab_err  = 0;
        bus.GO = 1'b1;
        @(posedge CLK); #1;
        chk("busy_on_go", bus.BUSY, 1);
        // Inputs after the latch edge must have no effect on this run
        bus.M  = {$urandom(), $urandom()};
        bus.E  = {$urandom(), $urandom()};
        bus.N  = {$urandom(), $urandom()} | 64'd1;
        bus.R2 = {$urandom(), $urandom()};
        cyc = 0;
        while (bus.DONE !== 1'b1 && cyc < 20000) begin
            @(posedge CLK); #1;
            cyc++;
        end
        chk("done_seen", bus.DONE, 1);
        res    = bus.RESULT;
        starts = mm_starts;
        chk("busy_in_fin", bus.BUSY, 0);
        chk("mm_n_copy", bus.MM_N, n);
        chk("operands_stable", stab_err, 0);
        repeat (3) @(posedge CLK);
        #1;
        chk("done_held", bus.DONE, 1);
        bus.GO = 1'b0;
        @(posedge CLK); #1;
        chk("done_clear", bus.DONE, 0);
        chk("busy_idle", bus.BUSY, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},     bus.BUSY, 0);
        chk({tag, "_done"},     bus.DONE, 0);
        chk({tag, "_result"},   bus.RESULT, 0);
        chk({tag, "_mm_start"}, bus.MM_START, 0);
        chk({tag, "_mm_a"},     bus.MM_A, 0);
        chk({tag, "_mm_b"},     bus.MM_B, 0);
        chk({tag, "_mm_n"},     bus.MM_N, 0);
    endtask

    task automatic start_case1();
        @(posedge CLK); #1;
        bus.M  = 64'd190;
        bus.E  = 64'd3;
        bus.N  = 64'd1189;
        bus.R2 = r2_of(64'd1189);
        mm_starts = 0;
        bus.GO = 1'b1;
    endtask

    initial begin
        vec_t tbl[5];
        logic [63:0] res, enc, n, m, e;
        int starts, cyc, s, dn;
        logic [63:0] n4, d4;

        tbl[0] = '{64'd190, 64'd3,   64'd1189, 64'd848};
        tbl[1] = '{64'd848, 64'd187, 64'd1189, 64'd190};
        tbl[2] = '{64'd190, 64'd0,   64'd1189, 64'd1};
        tbl[3] = '{64'd190, 64'd1,   64'd1189, 64'd190};
        tbl[4] = '{64'd0,   64'd5,   64'd1189, 64'd0};

        bus.GO = 1'b0;
        bus.M  = '0;
        bus.E  = '0;
        bus.N  = '0;
        bus.R2 = '0;
        RESET_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk_all_zero("reset");
        RESET_N = 1'b1;
        repeat (2) @(posedge CLK);

        for (int i = 0; i < 5; i++) begin
            run_one(tbl[i].m, tbl[i].e, tbl[i].n, res, starts);
            chk("tbl_result", res, tbl[i].res);
            chk("tbl_mm_starts", starts, exp_starts(tbl[i].e));
        end

        n4  = 64'd288230439905132863;
        d4  = 64'd172938262574058869;
        enc = ref_modexp(64'd21349, 64'd5, n4);
        run_one(64'd21349, 64'd5, n4, res, starts);
        chk("rsa_encrypt", res, enc);
        chk("rsa_enc_starts", starts, exp_starts(64'd5));
        run_one(enc, d4, n4, res, starts);
        chk("rsa_decrypt", res, 64'd21349);
        chk("rsa_dec_starts", starts, exp_starts(d4));

        for (int k = 0; k < 12; k++) begin
            n = {$urandom(), $urandom()} | 64'd1;
            if (n < 64'd3) n = 64'd3;
            m = {$urandom(), $urandom()} % n;
            if ($urandom_range(0, 3) == 0) e = 64'($urandom_range(0, 15));
            else e = {$urandom(), $urandom()};
            run_one(m, e, n, res, starts);
            chk("rand_result", res, ref_modexp(m, e, n));
            chk("rand_mm_starts", starts, exp_starts(e));
        end

        // Abort while squaring
        start_case1();
        cyc = 0;
        while (mm_starts < ABORT_AT && cyc < 5000) begin
            @(posedge CLK); #1;
            cyc++;
        end
        chk("abort_reached", (mm_starts >= ABORT_AT), 1);
        @(posedge CLK); #1;
        bus.GO = 1'b0;
        @(posedge CLK); #1;
        chk("abort_busy_drop", bus.BUSY, 0);
        s  = mm_starts;
        dn = 0;
        repeat (20) begin
            @(posedge CLK); #1;
            if (bus.DONE === 1'b1) dn++;
        end
        chk("abort_no_start", mm_starts - s, 0);
        chk("abort_no_done", dn, 0);
        run_one(64'd190, 64'd3, 64'd1189, res, starts);
        chk("after_abort_result", res, 64'd848);

        // Asynchronous reset during a multiply
        start_case1();
        cyc = 0;
        while (mm_starts < RESET_AT && cyc < 5000) begin
            @(posedge CLK); #1;
            cyc++;
        end
        chk("reset_reached_mult", (mm_starts >= RESET_AT), 1);
        @(posedge CLK); #1;
        #3;
        RESET_N = 1'b0;
        #1;
        chk_all_zero("async_reset");
        bus.GO = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        s = mm_starts;
        repeat (20) begin
            @(posedge CLK); #1;
        end
        chk("reset_no_start", mm_starts - s, 0);
        chk("reset_busy", bus.BUSY, 0);
        chk("reset_result_kept0", bus.RESULT, 0);
        run_one(64'd190, 64'd3, 64'd1189, res, starts);
        chk("after_reset_result", res, 64'd848);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
